// File: rtl/bp_pkg.sv
// Shared types for the fetch PC generator / prediction metadata pipeline.
package bp_pkg;

    typedef enum logic [1:0] {
        PC_IF_P4  = 2'b00,
        PC_EX_P4  = 2'b01,
        PC_BTB    = 2'b10,
        PC_EX_TGT = 2'b11
    } pcnext_sel_e;

    typedef struct packed {
        logic [31:0] pc;
        logic        pred;
        logic        hit;
        logic        valid;
    } bp_meta_t;

    localparam bp_meta_t BP_META_RST = '{pc: 32'h0, pred: 1'b0, hit: 1'b0, valid: 1'b0};

    localparam logic [1:0] UNCBR_JAL = 2'b10;

endpackage

// File: rtl/bp_fetch_pipe_if.sv
// Predictor-facing bus of the fetch pipe: IF controls in, IF indices and EXMEM write-back fields out.
interface bp_fetch_if #(
    parameter int INDEX_WIDTH   = 12,
    parameter int HISTORY_WIDTH = 4
);
    logic                        stall_i;
    logic [1:0]                  IF_PCnext_sel_i;
    logic                        IF_flush_i;
    logic [31:0]                 IF_btb_rd_target_i;
    logic                        IF_btb_hit_i;
    logic                        IF_prediction_i;
    logic [31:0]                 EXMEM_br_target_i;
    logic                        EXMEM_is_br_i;
    logic [1:0]                  EXMEM_is_uncbr_i;

    logic [31:0]                 IF_pc_o;
    logic [31-INDEX_WIDTH-2:0]   IF_PC_tag_o;
    logic [INDEX_WIDTH-1:0]      IF_btb_rd_index_o;
    logic [HISTORY_WIDTH-1:0]    IF_pht_rd_index_o;
    logic                        EXMEM_valid_o;
    logic [31:0]                 EXMEM_pc_o;
    logic [31:0]                 EXMEM_PCplus4_o;
    logic                        EXMEM_prediction_o;
    logic                        EXMEM_btb_hit_o;
    logic [INDEX_WIDTH-1:0]      EXMEM_btb_wr_index_o;
    logic [31-INDEX_WIDTH-2:0]   EXMEM_btb_wr_tag_o;
    logic [HISTORY_WIDTH-1:0]    EXMEM_pht_wr_index_o;

    modport master (
        output stall_i, IF_PCnext_sel_i, IF_flush_i, IF_btb_rd_target_i, IF_btb_hit_i,
               IF_prediction_i, EXMEM_br_target_i, EXMEM_is_br_i, EXMEM_is_uncbr_i,
        input  IF_pc_o, IF_PC_tag_o, IF_btb_rd_index_o, IF_pht_rd_index_o, EXMEM_valid_o,
               EXMEM_pc_o, EXMEM_PCplus4_o, EXMEM_prediction_o, EXMEM_btb_hit_o,
               EXMEM_btb_wr_index_o, EXMEM_btb_wr_tag_o, EXMEM_pht_wr_index_o
    );

    modport slave (
        input  stall_i, IF_PCnext_sel_i, IF_flush_i, IF_btb_rd_target_i, IF_btb_hit_i,
               IF_prediction_i, EXMEM_br_target_i, EXMEM_is_br_i, EXMEM_is_uncbr_i,
        output IF_pc_o, IF_PC_tag_o, IF_btb_rd_index_o, IF_pht_rd_index_o, EXMEM_valid_o,
               EXMEM_pc_o, EXMEM_PCplus4_o, EXMEM_prediction_o, EXMEM_btb_hit_o,
               EXMEM_btb_wr_index_o, EXMEM_btb_wr_tag_o, EXMEM_pht_wr_index_o
    );

endinterface

// File: rtl/bp_meta_stage.sv
// One pipeline register of prediction metadata; squash beats hold beats load.
module bp_meta_stage
    import bp_pkg::*;
(
    input  logic     clk_i,
    input  logic     rst_i,
    input  logic     hold_i,
    input  logic     squash_i,
    input  bp_meta_t d_i,
    output bp_meta_t q_o
);

    bp_meta_t r_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_q <= BP_META_RST;
        else if (squash_i)
            r_q <= BP_META_RST;
        else if (!hold_i)
            r_q <= d_i;
    end

    assign q_o = r_q;

endmodule

// File: rtl/bp_fetch_pipe.sv
// Fetch PC generator and ID/EX/MEM prediction-metadata pipe feeding the gshare predictor.
// Optional perf counters are built when BP_PERF_CNT_EN is defined.
module bp_fetch_pipe
    import bp_pkg::*;
#(
    parameter int          INDEX_WIDTH   = 12,
    parameter int          HISTORY_WIDTH = 4,
    parameter logic [31:0] RESET_PC      = 32'h0000_0000,
    parameter int          CNT_WIDTH     = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
`ifdef BP_PERF_CNT_EN
    output logic [CNT_WIDTH-1:0] perf_br_cnt_o,
    output logic [CNT_WIDTH-1:0] perf_mispred_cnt_o,
`endif
    bp_fetch_if.slave            bus
);

    localparam int NSTG = 3;   // 0: ID, 1: EX, 2: MEM

    logic [31:0]         r_pc;
    logic [31:0]         w_pc_next;
    logic [31:0]         w_mem_p4;
    logic [NSTG-1:0]     w_hold;
    logic [NSTG-1:0]     w_squash;
    bp_meta_t            w_d [NSTG];
    bp_meta_t            w_q [NSTG];
    bp_meta_t            w_mem;

    assign w_mem    = w_q[NSTG-1];
    assign w_mem_p4 = w_mem.pc + 32'd4;

    always_comb begin
        w_pc_next = r_pc + 32'd4;
        case (pcnext_sel_e'(bus.IF_PCnext_sel_i))
            PC_IF_P4:  w_pc_next = r_pc + 32'd4;
            PC_EX_P4:  w_pc_next = w_mem_p4;
            PC_BTB:    w_pc_next = bus.IF_btb_rd_target_i;
            PC_EX_TGT: w_pc_next = bus.EXMEM_br_target_i;
            default:   w_pc_next = r_pc + 32'd4;
        endcase
    end

    // Flush overrides stall: the PC follows the recovery path even while a load-use stall is up.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            r_pc <= RESET_PC;
        else if (bus.IF_flush_i || !bus.stall_i)
            r_pc <= w_pc_next;
    end

    // ID holds on stall; EX takes a bubble on stall; every stage dies on flush.
    assign w_hold   = {1'b0, 1'b0, bus.stall_i};
    assign w_squash = {bus.IF_flush_i, bus.IF_flush_i | bus.stall_i, bus.IF_flush_i};

    assign w_d[0] = '{pc: r_pc, pred: bus.IF_prediction_i, hit: bus.IF_btb_hit_i, valid: 1'b1};
    assign w_d[1] = w_q[0];
    assign w_d[2] = w_q[1];

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        bp_meta_stage u_stg (
            .clk_i    (clk_i),
            .rst_i    (rst_i),
            .hold_i   (w_hold[s]),
            .squash_i (w_squash[s]),
            .d_i      (w_d[s]),
            .q_o      (w_q[s])
        );
    end

    assign bus.IF_pc_o              = r_pc;
    assign bus.IF_PC_tag_o          = r_pc[31:INDEX_WIDTH+2];
    assign bus.IF_btb_rd_index_o    = r_pc[INDEX_WIDTH+1:2];
    assign bus.IF_pht_rd_index_o    = r_pc[HISTORY_WIDTH+1:2];

    assign bus.EXMEM_valid_o        = w_mem.valid;
    assign bus.EXMEM_pc_o           = w_mem.pc;
    assign bus.EXMEM_PCplus4_o      = w_mem_p4;
    assign bus.EXMEM_prediction_o   = w_mem.pred & w_mem.valid;
    assign bus.EXMEM_btb_hit_o      = w_mem.hit & w_mem.valid;
    assign bus.EXMEM_btb_wr_index_o = w_mem.pc[INDEX_WIDTH+1:2];
    assign bus.EXMEM_btb_wr_tag_o   = w_mem.pc[31:INDEX_WIDTH+2];
    assign bus.EXMEM_pht_wr_index_o = w_mem.pc[HISTORY_WIDTH+1:2];

`ifdef BP_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] r_br_cnt;
    logic [CNT_WIDTH-1:0] r_mis_cnt;
    logic                 w_br_commit;
    logic                 w_mispred;

    // JAL counts as a committed branch; JALR does not.
    assign w_br_commit = w_mem.valid & (bus.EXMEM_is_br_i | (bus.EXMEM_is_uncbr_i == UNCBR_JAL));
    assign w_mispred   = w_mem.valid & bus.IF_flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_br_cnt  <= '0;
            r_mis_cnt <= '0;
        end else begin
            if (w_br_commit)
                r_br_cnt <= r_br_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
            if (w_mispred)
                r_mis_cnt <= r_mis_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign perf_br_cnt_o      = r_br_cnt;
    assign perf_mispred_cnt_o = r_mis_cnt;
`endif

endmodule

// File: tb/tb_bp_fetch_pipe.sv
// Directed, table-driven bench for bp_fetch_pipe; perf-counter sequence runs when BP_PERF_CNT_EN is defined.
module tb_bp_fetch_pipe;

    typedef struct {
        logic        stall;
        logic        flush;
        logic [1:0]  sel;
        logic [31:0] tgt;
        logic        pred;
        logic        hit;
        logic [31:0] e_pc;
        logic        e_v;
        logic [31:0] e_mpc;
        logic        e_pred;
        logic        e_hit;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[$];

    bp_fetch_if #(.INDEX_WIDTH(12), .HISTORY_WIDTH(4)) bus ();

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br;
    logic [31:0] perf_mis;
`endif

    bp_fetch_pipe #(
        .INDEX_WIDTH   (12),
        .HISTORY_WIDTH (4),
        .RESET_PC      (32'h0000_0000),
        .CNT_WIDTH     (32)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
`ifdef BP_PERF_CNT_EN
        .perf_br_cnt_o      (perf_br),
        .perf_mispred_cnt_o (perf_mis),
`endif
        .bus                (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic fl, input logic [1:0] sel, input logic [31:0] tgt,
                       input logic pr, input logic ht, input logic [31:0] epc, input logic ev,
                       input logic [31:0] empc, input logic ep, input logic eh);
        vec_t v;
        v = '{st, fl, sel, tgt, pr, ht, epc, ev, empc, ep, eh};
        vecs.push_back(v);
    endtask

    task automatic drive(input logic st, input logic fl, input logic [1:0] sel, input logic [31:0] tgt,
                         input logic pr, input logic ht);
        bus.stall_i            = st;
        bus.IF_flush_i         = fl;
        bus.IF_PCnext_sel_i    = sel;
        bus.IF_btb_rd_target_i = tgt;
        bus.EXMEM_br_target_i  = tgt;
        bus.IF_prediction_i    = pr;
        bus.IF_btb_hit_i       = ht;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        bus.EXMEM_is_br_i    = 1'b0;
        bus.EXMEM_is_uncbr_i = 2'b00;

        //   st fl sel tgt           pr ht  pc            v  mpc           p  h
        add(0, 0, 0, 32'h0,        0, 0, 32'h4,        0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h8,        0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'hC,        1, 32'h0,   0, 0);
        add(0, 0, 2, 32'h40,       1, 1, 32'h40,       1, 32'h4,   0, 0);
        add(0, 0, 0, 32'h0,        1, 1, 32'h44,       1, 32'h8,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h48,       1, 32'hC,   1, 1);
        add(0, 0, 0, 32'h0,        0, 0, 32'h4C,       1, 32'h40,  1, 1);
        add(1, 0, 0, 32'h0,        0, 0, 32'h4C,       1, 32'h44,  0, 0);
        add(1, 0, 0, 32'h0,        0, 0, 32'h4C,       0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h50,       0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h54,       1, 32'h48,  0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h58,       1, 32'h4C,  0, 0);
        add(0, 1, 1, 32'h0,        0, 0, 32'h50,       0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h54,       0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h58,       0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h5C,       1, 32'h50,  0, 0);
        add(1, 1, 3, 32'h800,      0, 0, 32'h800,      0, 32'h0,   0, 0);
        add(1, 0, 0, 32'h0,        0, 0, 32'h800,      0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h804,      0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h808,      0, 32'h0,   0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h80C,      1, 32'h800, 0, 0);
        add(0, 0, 2, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 1, 32'h804, 0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h808, 0, 0);
        add(0, 0, 0, 32'h0,        0, 0, 32'h4,        1, 32'h80C, 0, 0);

        // Reset state
        #2;
        chk("rst_pc", bus.IF_pc_o, 32'h0);
        chk("rst_valid", {31'b0, bus.EXMEM_valid_o}, 32'h0);
        chk("rst_p4", bus.EXMEM_PCplus4_o, 32'h4);
        chk("rst_mpc", bus.EXMEM_pc_o, 32'h0);
        chk("rst_pred", {30'b0, bus.EXMEM_prediction_o, bus.EXMEM_btb_hit_o}, 32'h0);
        tick(2);
        chk("rst_hold_pc", bus.IF_pc_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_pc", bus.IF_pc_o, 32'h0);

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.stall, v.flush, v.sel, v.tgt, v.pred, v.hit);
            tick(1);
            chk($sformatf("r%0d_pc", i), bus.IF_pc_o, v.e_pc);
            chk($sformatf("r%0d_tag", i), {14'b0, bus.IF_PC_tag_o}, {14'b0, v.e_pc[31:14]});
            chk($sformatf("r%0d_rdidx", i), {20'b0, bus.IF_btb_rd_index_o}, {20'b0, v.e_pc[13:2]});
            chk($sformatf("r%0d_phtrd", i), {28'b0, bus.IF_pht_rd_index_o}, {28'b0, v.e_pc[5:2]});
            chk($sformatf("r%0d_valid", i), {31'b0, bus.EXMEM_valid_o}, {31'b0, v.e_v});
            chk($sformatf("r%0d_pred", i), {31'b0, bus.EXMEM_prediction_o}, {31'b0, v.e_pred});
            chk($sformatf("r%0d_hit", i), {31'b0, bus.EXMEM_btb_hit_o}, {31'b0, v.e_hit});
            if (v.e_v) begin
                chk($sformatf("r%0d_mpc", i), bus.EXMEM_pc_o, v.e_mpc);
                chk($sformatf("r%0d_p4", i), bus.EXMEM_PCplus4_o, v.e_mpc + 32'd4);
                chk($sformatf("r%0d_wridx", i), {20'b0, bus.EXMEM_btb_wr_index_o}, {20'b0, v.e_mpc[13:2]});
                chk($sformatf("r%0d_wrtag", i), {14'b0, bus.EXMEM_btb_wr_tag_o}, {14'b0, v.e_mpc[31:14]});
                chk($sformatf("r%0d_phtwr", i), {28'b0, bus.EXMEM_pht_wr_index_o}, {28'b0, v.e_mpc[5:2]});
            end
        end

        // Asynchronous reset in the middle of a flush+stall cycle
        drive(1'b1, 1'b1, 2'b11, 32'h800, 1'b1, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_pc", bus.IF_pc_o, 32'h0);
        chk("arst_valid", {31'b0, bus.EXMEM_valid_o}, 32'h0);
        chk("arst_p4", bus.EXMEM_PCplus4_o, 32'h4);
        tick(1);
        chk("arst_pc_edge", bus.IF_pc_o, 32'h0);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;

`ifdef BP_PERF_CNT_EN
        chk("perf_rst_br", perf_br, 32'd0);
        chk("perf_rst_mis", perf_mis, 32'd0);
        tick(3);
        chk("perf_v0", {31'b0, bus.EXMEM_valid_o}, 32'd1);
        bus.EXMEM_is_br_i = 1'b1;
        tick(2);
        drive(1'b0, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0);
        tick(1);
        chk("perf_br3", perf_br, 32'd3);
        chk("perf_mis1", perf_mis, 32'd1);
        tick(1);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        tick(3);
        chk("perf_v1", {31'b0, bus.EXMEM_valid_o}, 32'd1);
        chk("perf_br_gated", perf_br, 32'd3);
        chk("perf_mis_gated", perf_mis, 32'd1);
        tick(1);
        drive(1'b0, 1'b1, 2'b01, 32'h0, 1'b0, 1'b0);
        tick(1);
        drive(1'b0, 1'b0, 2'b00, 32'h0, 1'b0, 1'b0);
        bus.EXMEM_is_br_i = 1'b0;
        tick(3);
        chk("perf_br5", perf_br, 32'd5);
        chk("perf_mis2", perf_mis, 32'd2);
        bus.EXMEM_is_uncbr_i = 2'b11;
        tick(1);
        chk("perf_jalr", perf_br, 32'd5);
        bus.EXMEM_is_uncbr_i = 2'b10;
        tick(1);
        chk("perf_jal", perf_br, 32'd6);
        bus.EXMEM_is_uncbr_i = 2'b00;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
